mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch stage and the load/store (MEM) stage of the RV core.
- Serialises the two requesters and runs the req/ack handshake to memory.
- Returns read data and one-cycle acks to the requesters, and drives stall outputs to the pipeline.
- The data side follows the decoder's read_mem/write_mem (word-only) signals.

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store onto one memory port with streak-limited data priority and a BUSY timeout
module mem_port_arbiter #(
  parameter int XLEN            = 64,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_ack_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_ack_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            err_o,
  output logic            stall_if_o,
  output logic            stall_mem_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] MAX_S    = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic [3:0]      streak_q, streak_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic            if_ack_q, if_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic            d_win, finish;

  // data wins unless fetch is waiting and data has used up its streak
  assign d_win  = d_req_i & ~(if_req_i & (streak_q == MAX_S));
  assign finish = mem_ack_i | (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: if (if_req_i | d_req_i) begin
        state_d     = S_BUSY;
        owner_d     = d_win;
        mem_req_d   = 1'b1;
        mem_we_d    = d_win & d_we_i;
        mem_addr_d  = d_win ? d_addr_i : if_addr_i;
        mem_wdata_d = d_win ? d_wdata_i : '0;
        streak_d    = (d_win & if_req_i) ? ((streak_q == MAX_S) ? streak_q : streak_q + 4'd1) : 4'd0;
      end
      S_BUSY: begin
        tmo_d = tmo_q + 8'd1;
        if (finish) begin
          state_d    = S_DONE;
          tmo_d      = 8'd0;
          mem_req_d  = 1'b0;
          if_ack_d   = ~owner_q;
          d_ack_d    = owner_q;
          err_d      = ~mem_ack_i;
          if_rdata_d = owner_q ? if_rdata_q : (mem_ack_i ? mem_rdata_i : '0);
          d_rdata_d  = owner_q ? (mem_ack_i ? mem_rdata_i : '0) : d_rdata_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign err_o       = err_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign stall_if_o  = if_req_i & ~if_ack_q;
  assign stall_mem_o = d_req_i & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, handshake, wait states, timeout and async reset
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, d_req, d_we, d_ack, mem_req, mem_we, mem_ack, err, stall_if, stall_mem;
  logic [63:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  int          n_vec = 0;
  int          n_bad = 0;

  mem_port_arbiter #(.XLEN(64), .MAX_DATA_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack), .d_rdata_o(d_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .err_o(err), .stall_if_o(stall_if), .stall_mem_o(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_acks", {62'd0, if_ack, d_ack}, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    rst_n = 1'b1;
    step();
    // fetch only, zero-wait memory
    if_req = 1; if_addr = 64'h1000;
    #1 chk("f_stall0", 64'(stall_if), 64'd1);
    step();
    chk("f_mem_req", 64'(mem_req), 64'd1);
    chk("f_mem_we", 64'(mem_we), 64'd0);
    chk("f_mem_addr", mem_addr, 64'h1000);
    chk("f_stall1", 64'(stall_if), 64'd1);
    mem_ack = 1; mem_rdata = 64'h13;
    step();
    chk("f_ack", 64'(if_ack), 64'd1);
    chk("f_rdata", if_rdata, 64'h13);
    chk("f_mem_req_drop", 64'(mem_req), 64'd0);
    chk("f_stall2", 64'(stall_if), 64'd0);
    chk("f_err", 64'(err), 64'd0);
    mem_ack = 0; if_req = 0;
    step();
    chk("f_ack_clr", 64'(if_ack), 64'd0);
    // simultaneous: store first, fetch three cycles later
    if_req = 1; if_addr = 64'h1004; d_req = 1; d_we = 1; d_addr = 64'h2000; d_wdata = 64'hABCD;
    #1 chk("s_stall_mem", 64'(stall_mem), 64'd1);
    step();
    chk("s_d_we", 64'(mem_we), 64'd1);
    chk("s_d_addr", mem_addr, 64'h2000);
    chk("s_d_wdata", mem_wdata, 64'hABCD);
    mem_ack = 1; mem_rdata = 64'hDEAD;
    step();
    chk("s_d_ack", {62'd0, if_ack, d_ack}, 64'd1);
    chk("s_stall_mem0", 64'(stall_mem), 64'd0);
    chk("s_stall_if1", 64'(stall_if), 64'd1);
    mem_ack = 0; d_req = 0; d_we = 0;
    step();
    chk("s_idle_acks", {62'd0, if_ack, d_ack}, 64'd0);
    step();
    chk("s_f_addr", mem_addr, 64'h1004);
    chk("s_f_we", {62'd0, mem_we, |mem_wdata}, 64'd0);
    mem_ack = 1; mem_rdata = 64'h17;
    step();
    chk("s_if_ack", {62'd0, if_ack, d_ack}, 64'd2);
    chk("s_if_rdata", if_rdata, 64'h17);
    mem_ack = 0; if_req = 0;
    step();
    // starvation: fetch waits behind four data grants
    if_req = 1; if_addr = 64'h4000; d_req = 1; d_we = 0;
    for (int i = 0; i < 6; i++) begin
      d_addr = 64'h5000 + 64'(8 * i);
      step();
      chk($sformatf("st_owner%0d", i), mem_addr, (i == 4) ? 64'h4000 : 64'h5000 + 64'(8 * i));
      mem_ack = 1; mem_rdata = (i == 4) ? 64'h4444 : 64'h100 + 64'(i);
      step();
      chk($sformatf("st_ack%0d", i), {62'd0, if_ack, d_ack}, (i == 4) ? 64'd2 : 64'd1);
      if (i == 4) chk("st_streak0", 64'(dut.streak_q), 64'd0);
      mem_ack = 0;
      step();
    end
    if_req = 0; d_req = 0;
    step();
    // wait states: ack after five idle BUSY cycles
    d_req = 1; d_we = 0; d_addr = 64'h3008;
    step();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("w_req%0d", k), 64'(mem_req), 64'd1);
      chk($sformatf("w_addr%0d", k), mem_addr, 64'h3008);
      if (k == 5) begin mem_ack = 1; mem_rdata = 64'h55; end
      step();
    end
    chk("w_d_ack", {62'd0, if_ack, d_ack}, 64'd1);
    chk("w_d_rdata", d_rdata, 64'h55);
    chk("w_if_rdata", if_rdata, 64'h4444);
    chk("w_req_drop", 64'(mem_req), 64'd0);
    mem_ack = 0; d_req = 0;
    step();
    // timeout after eight BUSY cycles
    d_req = 1; d_we = 0; d_addr = 64'h6000;
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t_req%0d", k), 64'(mem_req), 64'd1);
      step();
    end
    chk("t_req_drop", 64'(mem_req), 64'd0);
    chk("t_ack_err", {61'd0, err, if_ack, d_ack}, 64'd5);
    chk("t_rdata0", d_rdata, 64'd0);
    d_req = 0;
    step();
    chk("t_err_clr", 64'(err), 64'd0);
    if_req = 1; if_addr = 64'h7000;
    step();
    chk("t_next_addr", mem_addr, 64'h7000);
    mem_ack = 1; mem_rdata = 64'h21;
    step();
    chk("t_next_ack", {61'd0, err, if_ack, d_ack}, 64'd2);
    chk("t_next_rdata", if_rdata, 64'h21);
    mem_ack = 0; if_req = 0;
    step();
    // asynchronous reset while BUSY
    if_req = 1; if_addr = 64'h8000;
    step();
    chk("r_busy", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("r_async", {61'd0, mem_req, if_ack, d_ack}, 64'd0);
    chk("r_err", 64'(err), 64'd0);
    @(negedge clk);
    if_addr = 64'h8008;
    rst_n = 1'b1;
    chk("r_idle", 64'(dut.state_q), 64'd0);
    step();
    chk("r_new_addr", mem_addr, 64'h8008);
    mem_ack = 1; mem_rdata = 64'h33;
    step();
    chk("r_new_ack", 64'(if_ack), 64'd1);
    chk("r_new_rdata", if_rdata, 64'h33);
    mem_ack = 0; if_req = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
